// File: rtl/hash_rs.sv
// hash_rs: reservation station for the hash FU; holds dispatched ops until both sources are valid, snoops the CDB.
// Latency: issue strobe is registered, so an op ready in cycle N strobes in N+2 at the earliest; HASH_RS_OLDEST_FIRST_EN picks oldest.
// Backpressure: disp_ready low when full (upstream holds); no selection while fu_busy or while input_transmit is high.
module hash_rs #(
   parameter  int DEPTH = 4,
   localparam int IDXW  = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   input  logic [7:0]           disp_operand,
   input  logic [1:0]           disp_dep_rdy,
   input  logic [1:0][3:0]      disp_dep_tag,
   input  logic [1:0][7:0]      disp_dep_val,
   input  logic [7:0]           disp_wbs,
   input  logic [7:0]           disp_flags,
   input  logic [3:0]           disp_robid,
   input  logic                 cdb_transmit,
   input  logic [3:0]           cdb_id,
   input  logic [7:0]           cdb_val,
   input  logic                 fu_busy,
   output logic                 input_transmit,
   output logic [7:0]           operand,
   output logic [1:0][7:0]      depvals,
   output logic [7:0]           wbs,
   output logic [7:0]           flags,
   output logic [3:0]           robid,
   output logic [IDXW:0]        occupancy
);

   typedef struct packed {
      logic            valid;
      logic [7:0]      operand;
      logic [1:0]      rdy;
      logic [1:0][3:0] tag;
      logic [1:0][7:0] val;
      logic [7:0]      wbs;
      logic [7:0]      flags;
      logic [3:0]      robid;
`ifdef HASH_RS_OLDEST_FIRST_EN
      logic [IDXW:0]   seq;
`endif
   } entry_t;

   typedef struct packed {
      logic [7:0]      operand;
      logic [1:0][7:0] depvals;
      logic [7:0]      wbs;
      logic [7:0]      flags;
      logic [3:0]      robid;
   } issue_t;

   entry_t          ent_q [DEPTH];
   entry_t          ent_d [DEPTH];
   entry_t          new_ent;
   issue_t          iss_q, iss_d;
   logic            input_transmit_q, input_transmit_d;

   logic            free_vld;
   logic [IDXW-1:0] free_idx;
   logic            sel_vld;
   logic [IDXW-1:0] sel_idx;
   logic [IDXW:0]   occ;

`ifdef HASH_RS_OLDEST_FIRST_EN
   logic [IDXW:0]   seq_ctr_q, seq_ctr_d;
   logic [IDXW:0]   age, best_age;
`endif

   // Lowest free slot and population count, both from registered valid bits only.
   always_comb begin
      free_vld = 1'b0;
      free_idx = '0;
      occ      = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!ent_q[i].valid) begin
            free_vld = 1'b1;
            free_idx = IDXW'(i);
         end
         occ = occ + (IDXW+1)'(ent_q[i].valid);
      end
   end

   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
`ifdef HASH_RS_OLDEST_FIRST_EN
      age      = '0;
      best_age = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid && (&ent_q[i].rdy) && !fu_busy && !input_transmit_q) begin
`ifdef HASH_RS_OLDEST_FIRST_EN
            age = seq_ctr_q - ent_q[i].seq;
            if (!sel_vld || (age > best_age)) begin
               sel_vld  = 1'b1;
               sel_idx  = IDXW'(i);
               best_age = age;
            end
`else
            if (!sel_vld) begin
               sel_vld = 1'b1;
               sel_idx = IDXW'(i);
            end
`endif
         end
      end
   end

   // Incoming entry; a same-cycle broadcast of a pending tag is captured here so the wakeup is not lost.
   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.operand = disp_operand;
      new_ent.wbs     = disp_wbs;
      new_ent.flags   = disp_flags;
      new_ent.robid   = disp_robid;
      for (int s = 0; s < 2; s++) begin
         new_ent.tag[s] = disp_dep_tag[s];
         if (disp_dep_rdy[s]) begin
            new_ent.rdy[s] = 1'b1;
            new_ent.val[s] = disp_dep_val[s];
         end else if (cdb_transmit && (cdb_id == disp_dep_tag[s])) begin
            new_ent.rdy[s] = 1'b1;
            new_ent.val[s] = cdb_val;
         end
      end
`ifdef HASH_RS_OLDEST_FIRST_EN
      new_ent.seq = seq_ctr_q;
`endif
   end

   always_comb begin
      ent_d            = ent_q;
      iss_d            = iss_q;
      input_transmit_d = 1'b0;
`ifdef HASH_RS_OLDEST_FIRST_EN
      seq_ctr_d        = seq_ctr_q;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         for (int s = 0; s < 2; s++) begin
            if (ent_q[i].valid && !ent_q[i].rdy[s] && cdb_transmit && (ent_q[i].tag[s] == cdb_id)) begin
               ent_d[i].rdy[s] = 1'b1;
               ent_d[i].val[s] = cdb_val;
            end
         end
      end

      if (sel_vld) begin
         ent_d[sel_idx].valid = 1'b0;
         input_transmit_d     = 1'b1;
         iss_d.operand        = ent_q[sel_idx].operand;
         iss_d.depvals        = ent_q[sel_idx].val;
         iss_d.wbs            = ent_q[sel_idx].wbs;
         iss_d.flags          = ent_q[sel_idx].flags;
         iss_d.robid          = ent_q[sel_idx].robid;
      end

      if (disp_valid && free_vld) begin
         ent_d[free_idx] = new_ent;
`ifdef HASH_RS_OLDEST_FIRST_EN
         seq_ctr_d       = seq_ctr_q + 1'b1;
`endif
      end

      // Flush wins over everything: the pending selection is dropped and the payload keeps its old value.
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].valid = 1'b0;
         end
         input_transmit_d = 1'b0;
         iss_d            = iss_q;
`ifdef HASH_RS_OLDEST_FIRST_EN
         seq_ctr_d        = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         iss_q            <= '0;
         input_transmit_q <= 1'b0;
`ifdef HASH_RS_OLDEST_FIRST_EN
         seq_ctr_q        <= '0;
`endif
      end else begin
         ent_q            <= ent_d;
         iss_q            <= iss_d;
         input_transmit_q <= input_transmit_d;
`ifdef HASH_RS_OLDEST_FIRST_EN
         seq_ctr_q        <= seq_ctr_d;
`endif
      end
   end

   assign disp_ready     = free_vld;
   assign occupancy      = occ;
   assign input_transmit = input_transmit_q;
   assign operand        = iss_q.operand;
   assign depvals        = iss_q.depvals;
   assign wbs            = iss_q.wbs;
   assign flags          = iss_q.flags;
   assign robid          = iss_q.robid;

endmodule
